// File: rtl/mc8051_mux_pipe.sv
// rtl/mc8051_mux_pipe.sv - registered operand/address selector with 2-entry skid buffer
//
// Selects one of NUM_SRC packed data sources and forms an internal-RAM/XDATA
// address from the requested addressing mode. Each result is held in a
// 2-entry FIFO with a valid/ready handshake on both sides.
//
// Optional feature macro: MUX_SEL_CHK_EN
//   defined   : o_err flags entries with an out-of-range data select or an
//               illegal address mode (5-7).
//   undefined : o_err is constant 0.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_vld / o_rdy      request handshake (push on i_vld && o_rdy)
//   i_src              NUM_SRC packed sources, source k at [k*DATA_W +: DATA_W]
//   i_data_sel         data source index
//   i_addr_mode        0=RN 1=BASE 2=BASE_OFFS 3=IND8 4=BIT, 5-7 illegal
//   i_base, i_offs     base address and offset/direct/bit address
//   i_psw_rs, i_rn_idx register bank select and register number
//   o_vld / i_rdy      result handshake (pop on o_vld && i_rdy)
//   o_data, o_addr     head entry data and address
//   o_err              head entry illegal flag
module mc8051_mux_pipe #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [NUM_SRC*DATA_W-1:0] i_src,
    input  logic [SEL_W-1:0]          i_data_sel,
    input  logic [2:0]                i_addr_mode,
    input  logic [ADDR_W-1:0]         i_base,
    input  logic [7:0]                i_offs,
    input  logic [1:0]                i_psw_rs,
    input  logic [2:0]                i_rn_idx,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [DATA_W-1:0]         o_data,
    output logic [ADDR_W-1:0]         o_addr,
    output logic                      o_err
);

    typedef enum logic [2:0] {
        MODE_RN        = 3'd0,
        MODE_BASE      = 3'd1,
        MODE_BASE_OFFS = 3'd2,
        MODE_IND8      = 3'd3,
        MODE_BIT       = 3'd4
    } addr_mode_e;

    logic [DATA_W-1:0] new_data;
    logic [ADDR_W-1:0] new_addr;
    logic              new_err;
    logic [7:0]        bit_addr;

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
    logic              head_err_q, head_err_d, tail_err_q, tail_err_d;
    logic              push, pop;

    // Data select: an index at or beyond NUM_SRC leaves new_data at 0.
    always_comb begin
        new_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(i_data_sel) == k) begin
                new_data = i_src[k*DATA_W +: DATA_W];
            end
        end
    end

    // 8051 bit addressing: bits 0x00-0x7F live in RAM bytes 0x20-0x2F,
    // bits 0x80-0xFF live in the bit-addressable SFRs (byte address = bit & 0xF8).
    assign bit_addr = i_offs[7] ? {i_offs[7:3], 3'b000}
                                : (8'h20 + {4'b0000, i_offs[6:3]});

    always_comb begin
        new_addr = '0;
        case (i_addr_mode)
            MODE_RN:        new_addr = ADDR_W'({i_psw_rs, i_rn_idx});
            MODE_BASE:      new_addr = i_base;
            MODE_BASE_OFFS: new_addr = i_base + ADDR_W'(i_offs);
            MODE_IND8:      new_addr = ADDR_W'(i_offs);
            MODE_BIT:       new_addr = ADDR_W'(bit_addr);
            default:        new_addr = '0;
        endcase
    end

`ifdef MUX_SEL_CHK_EN
    assign new_err = (32'(i_data_sel) >= 32'(NUM_SRC)) || (i_addr_mode > MODE_BIT);
`else
    assign new_err = 1'b0;
`endif

    // o_rdy depends only on the registered count, so i_rdy never reaches it
    // combinationally; a pop at a full buffer raises o_rdy one cycle later.
    assign o_rdy = (cnt_q != 2'd2);
    assign o_vld = (cnt_q != 2'd0);
    assign push  = i_vld && o_rdy;
    assign pop   = o_vld && i_rdy;

    always_comb begin
        cnt_d       = cnt_q;
        head_data_d = head_data_q;
        head_addr_d = head_addr_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_addr_d = tail_addr_q;
        tail_err_d  = tail_err_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_data_d = new_data;
                    head_addr_d = new_addr;
                    head_err_d  = new_err;
                end else begin
                    tail_data_d = new_data;
                    tail_addr_d = new_addr;
                    tail_err_d  = new_err;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_data_d = tail_data_q;
                    head_addr_d = tail_addr_q;
                    head_err_d  = tail_err_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at count 1: the new entry replaces the head.
                head_data_d = new_data;
                head_addr_d = new_addr;
                head_err_d  = new_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= 2'd0;
            head_data_q <= '0;
            head_addr_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_addr_q <= '0;
            tail_err_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            head_data_q <= head_data_d;
            head_addr_q <= head_addr_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_addr_q <= tail_addr_d;
            tail_err_q  <= tail_err_d;
        end
    end

    assign o_data = head_data_q;
    assign o_addr = head_addr_q;
    assign o_err  = head_err_q;

endmodule

// File: tb/tb_mc8051_mux_pipe.sv
// tb/tb_mc8051_mux_pipe.sv - directed scoreboard bench for mc8051_mux_pipe
module tb_mc8051_mux_pipe;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NS = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          i_rst, i_vld, o_rdy, o_vld, i_rdy, o_err;
    logic [NS*DW-1:0] i_src;
    logic [SW-1:0] i_data_sel;
    logic [2:0]    i_addr_mode;
    logic [AW-1:0] i_base;
    logic [7:0]    i_offs;
    logic [1:0]    i_psw_rs;
    logic [2:0]    i_rn_idx;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_addr;

    logic [DW-1:0] src [NS];

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        i_src = '0;
        for (int k = 0; k < NS; k++) i_src[k*DW +: DW] = src[k];
    end

    mc8051_mux_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .SEL_W(SW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_src(i_src),
        .i_data_sel(i_data_sel), .i_addr_mode(i_addr_mode), .i_base(i_base),
        .i_offs(i_offs), .i_psw_rs(i_psw_rs), .i_rn_idx(i_rn_idx), .o_vld(o_vld),
        .i_rdy(i_rdy), .o_data(o_data), .o_addr(o_addr), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic exp_t model();
        exp_t e;
        e.d = (int'(i_data_sel) < NS) ? src[i_data_sel] : '0;
        case (i_addr_mode)
            3'd0: e.a = AW'(i_psw_rs) * 16'd8 + AW'(i_rn_idx);
            3'd1: e.a = i_base;
            3'd2: e.a = AW'((32'(i_base) + 32'(i_offs)) % 65536);
            3'd3: e.a = AW'(i_offs);
            3'd4: e.a = (i_offs < 8'h80) ? AW'(8'h20 + i_offs / 8) : AW'(i_offs & 8'hF8);
            default: e.a = '0;
        endcase
`ifdef MUX_SEL_CHK_EN
        e.e = (int'(i_data_sel) >= NS) || (i_addr_mode >= 3'd5);
`else
        e.e = 1'b0;
`endif
        return e;
    endfunction

    // Inputs are stable here (#1 after the last edge): check any pop about to
    // happen against the scoreboard, record any push, then advance one edge.
    task automatic tick();
        exp_t e;
        if (!i_rst && o_vld && i_rdy) begin
            chk("sb_nonempty_on_pop", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data", 32'(o_data), 32'(e.d));
                chk("sb_addr", 32'(o_addr), 32'(e.a));
                chk("sb_err", 32'(o_err), 32'(e.e));
            end
        end
        if (!i_rst && i_vld && o_rdy) sb.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] mode, input logic [SW-1:0] sel,
                       input logic [AW-1:0] base, input logic [7:0] offs,
                       input logic [1:0] rs, input logic [2:0] n);
        i_vld = 1'b1; i_addr_mode = mode; i_data_sel = sel;
        i_base = base; i_offs = offs; i_psw_rs = rs; i_rn_idx = n;
    endtask

    initial begin
        logic exp_err7;
`ifdef MUX_SEL_CHK_EN
        exp_err7 = 1'b1;
`else
        exp_err7 = 1'b0;
`endif
        for (int k = 0; k < NS; k++) src[k] = 8'h30 + 8'(k);
        src[3] = 8'hA5;
        i_rst = 1'b1; i_vld = 1'b0; i_rdy = 1'b0;
        req(3'd0, '0, '0, '0, '0, '0);
        i_vld = 1'b0;
        @(posedge clk); #1;
        tick();
        chk("rst_vld", 32'(o_vld), 0);
        chk("rst_rdy", 32'(o_rdy), 1);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_err", 32'(o_err), 0);
        i_rst = 1'b0;
        i_rdy = 1'b1;

        // RN, first-push latency
        req(3'd0, 3'd3, 16'h1234, 8'h00, 2'b10, 3'd5);
        tick();
        chk("rn_vld", 32'(o_vld), 1);
        chk("rn_addr", 32'(o_addr), 32'h0015);
        chk("rn_data", 32'(o_data), 32'hA5);

        // Back-to-back pushes with pop at count 1
        req(3'd4, 3'd0, 16'h0000, 8'h2F, 2'b00, 3'd0); tick();
        chk("bit_lo_addr", 32'(o_addr), 32'h0025);
        req(3'd4, 3'd1, 16'h0000, 8'hE3, 2'b00, 3'd0); tick();
        chk("bit_hi_addr", 32'(o_addr), 32'h00E0);
        req(3'd2, 3'd2, 16'hFFF0, 8'h20, 2'b00, 3'd0); tick();
        chk("boffs_wrap", 32'(o_addr), 32'h0010);
        req(3'd1, 3'd4, 16'hBEEF, 8'h77, 2'b00, 3'd0); tick();
        chk("base_addr", 32'(o_addr), 32'hBEEF);
        req(3'd3, 3'd7, 16'h5555, 8'h44, 2'b11, 3'd7); tick();
        chk("sel7_data", 32'(o_data), 0);
        chk("sel7_err", 32'(o_err), 32'(exp_err7));
        chk("ind8_addr", 32'(o_addr), 32'h0044);
        req(3'd6, 3'd5, 16'h5555, 8'h44, 2'b11, 3'd7); tick();
        chk("badmode_addr", 32'(o_addr), 0);
        chk("badmode_err", 32'(o_err), 32'(exp_err7));
        i_vld = 1'b0; tick();
        chk("drain_vld", 32'(o_vld), 0);

        // Stall: fill, hold, release
        i_rdy = 1'b0;
        req(3'd3, 3'd0, 16'h0, 8'h11, 2'b00, 3'd0); tick();
        chk("fill1_rdy", 32'(o_rdy), 1);
        req(3'd3, 3'd1, 16'h0, 8'h22, 2'b00, 3'd0); tick();
        chk("full_rdy", 32'(o_rdy), 0);
        chk("full_head", 32'(o_data), 32'h30);
        req(3'd3, 3'd2, 16'h0, 8'h33, 2'b00, 3'd0); tick();
        chk("stall_addr", 32'(o_addr), 32'h0011);
        chk("stall_rdy", 32'(o_rdy), 0);
        i_rdy = 1'b1; tick();
        chk("rel_rdy", 32'(o_rdy), 1);
        chk("rel_head", 32'(o_addr), 32'h0022);
        tick();
        chk("third_head", 32'(o_addr), 32'h0033);
        i_vld = 1'b0; tick();
        chk("stall_drain_vld", 32'(o_vld), 0);

        // Reset while full
        i_rdy = 1'b0;
        req(3'd1, 3'd1, 16'hAAAA, 8'h0, 2'b00, 3'd0); tick();
        req(3'd1, 3'd2, 16'hBBBB, 8'h0, 2'b00, 3'd0); tick();
        chk("pre_rst_rdy", 32'(o_rdy), 0);
        i_vld = 1'b0; i_rst = 1'b1; i_rdy = 1'b1; tick();
        sb.delete();
        chk("mid_rst_vld", 32'(o_vld), 0);
        chk("mid_rst_rdy", 32'(o_rdy), 1);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_addr", 32'(o_addr), 0);
        chk("mid_rst_err", 32'(o_err), 0);
        i_rst = 1'b0;

        req(3'd0, 3'd5, 16'h0, 8'h0, 2'b01, 3'd2); tick();
        chk("post_rst_addr", 32'(o_addr), 32'h000A);
        i_vld = 1'b0;
        for (int t = 0; t < 10 && sb.size() != 0; t++) tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
